// File: rtl/mac_pkg.sv
// Shared definitions for the MAC dot-product sequencer.
//   DATA_W  : operand width, fixed by the Dadda_Mult16 multiplier
//   PROD_W  : full product width (2*DATA_W)
//   state_t : sequencer FSM encoding (StIdle/StRun/StDrain/StDone)
package mac_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

endpackage

// File: rtl/Dadda_Mult16.sv
// Unsigned 16x16 multiplier used by the MAC datapath.
//   a : operand A (DATA_W)
//   b : operand B (DATA_W)
//   p : full unsigned product (PROD_W), purely combinational
// Written behaviourally; synthesis maps it onto a reduction tree.
module Dadda_Mult16
  import mac_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer around Dadda_Mult16.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start, len          : job start pulse and pair count, sampled in idle only
//   busy                : high whenever the sequencer is not idle
//   in_valid/in_ready   : operand-pair handshake, in_a/in_b operands
//   out_valid/out_ready : result handshake, out_acc sum, out_ovf sticky wrap flag
module mac_dot_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 40,  // must be >= PROD_W
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  a_r, b_r;
  logic               v1, v2;
  logic [ACC_W-1:0]   p_r;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum;

  logic start_job, accept, last_beat;

  assign start_job = (state_q == StIdle) && start;
  // in_ready depends only on registered state, never on in_valid.
  assign in_ready  = (state_q == StRun);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && ((cnt_q + LEN_W'(1)) == len_q);

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = (len == '0) ? StDone : StRun;
      end
      StRun: begin
        if (last_beat) state_d = StDrain;
      end
      StDrain: begin
        // Leave only once the last product has landed in the accumulator.
        if (!v1 && !v2) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_job) begin
        len_q <= len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_r <= in_a;
        b_r <= in_b;
      end
    end
  end

  Dadda_Mult16 u_mult (
    .a (a_r),
    .b (b_r),
    .p (prod)
  );

  // Stage 2: registered, zero-extended product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= '0;
      v2  <= 1'b0;
    end else begin
      p_r <= ACC_W'(prod);
      v2  <= v1;
    end
  end

  assign sum = {1'b0, acc} + {1'b0, p_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_job) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (v2) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
    end
  end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Self-checking bench for mac_dot_ctrl: a 40-bit and a 32-bit accumulator instance share
// all stimulus; results are compared with a plain-arithmetic sum of products.
module tb_mac_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_ready = 1'b0;

  logic        busy40, in_ready40, out_valid40, out_ovf40;
  logic [39:0] out_acc40;
  logic        busy32, in_ready32, out_valid32, out_ovf32;
  logic [31:0] out_acc32;

  int errors = 0;
  int checks = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  mac_dot_ctrl #(.ACC_W(40), .LEN_W(8)) dut40 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy40),
    .in_valid  (in_valid),
    .in_ready  (in_ready40),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid40),
    .out_ready (out_ready),
    .out_acc   (out_acc40),
    .out_ovf   (out_ovf40)
  );

  mac_dot_ctrl #(.ACC_W(32), .LEN_W(8)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy32),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .out_acc   (out_acc32),
    .out_ovf   (out_ovf32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":busy40"},  64'(busy40), 64'd0);
    check({tag, ":ready40"}, 64'(in_ready40), 64'd0);
    check({tag, ":valid40"}, 64'(out_valid40), 64'd0);
    check({tag, ":acc40"},   64'(out_acc40), 64'd0);
    check({tag, ":ovf40"},   64'(out_ovf40), 64'd0);
    check({tag, ":busy32"},  64'(busy32), 64'd0);
    check({tag, ":acc32"},   64'(out_acc32), 64'd0);
    check({tag, ":ovf32"},   64'(out_ovf32), 64'd0);
  endtask

  // Runs one job from qa/qb. gaps inserts random in_valid bubbles; hold keeps out_ready low
  // for that many cycles in DONE and pulses start in the middle of the wait.
  task automatic run_job(input string name, input bit gaps, input int hold);
    int          n;
    int          i;
    int          cyc;
    bit          took;
    logic [63:0] total;
    logic [39:0] held40;
    logic [31:0] held32;
    n     = qa.size();
    total = 64'd0;
    foreach (qa[k]) total += 64'(qa[k]) * 64'(qb[k]);

    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom_range(0, 255));
    check({name, ":busy"}, 64'(busy40), 64'd1);

    if (n == 0) begin
      check({name, ":len0_valid"}, 64'(out_valid40), 64'd1);
      check({name, ":len0_ready"}, 64'(in_ready40), 64'd0);
    end else begin
      i   = 0;
      cyc = 0;
      while (i < n && cyc < 2000) begin
        in_valid = !(gaps && ($urandom_range(0, 2) == 0));
        in_a     = qa[i];
        in_b     = qb[i];
        took     = in_valid && in_ready40;
        @(posedge clk); #1;
        cyc++;
        if (took) i++;
      end
      in_valid = 1'b0;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      check({name, ":beats_accepted"}, 64'(i), 64'(n));
      check({name, ":drain_ready"}, 64'(in_ready40), 64'd0);
      cyc = 0;
      while (!out_valid40 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check({name, ":latency"}, 64'(cyc), 64'd3);
    end

    check({name, ":valid40"}, 64'(out_valid40), 64'd1);
    check({name, ":valid32"}, 64'(out_valid32), 64'd1);
    check({name, ":acc40"}, 64'(out_acc40), total % (64'd1 << 40));
    check({name, ":ovf40"}, 64'(out_ovf40), 64'(total >= (64'd1 << 40)));
    check({name, ":acc32"}, 64'(out_acc32), total % (64'd1 << 32));
    check({name, ":ovf32"}, 64'(out_ovf32), 64'(total >= (64'd1 << 32)));

    if (hold > 0) begin
      held40 = out_acc40;
      held32 = out_acc32;
      for (int h = 0; h < hold; h++) begin
        start = (h == 2);
        len   = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
      end
      check({name, ":held_valid"}, 64'(out_valid40), 64'd1);
      check({name, ":held_acc40"}, 64'(out_acc40), 64'(held40));
      check({name, ":held_acc32"}, 64'(out_acc32), 64'(held32));
    end

    // Handshake with a coincident start, which must be ignored.
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd3;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check({name, ":post_valid"}, 64'(out_valid40), 64'd0);
    check({name, ":post_busy40"}, 64'(busy40), 64'd0);
    check({name, ":post_busy32"}, 64'(busy32), 64'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({"idle", ":busy"}, 64'(busy40), 64'd0);

    qa = '{16'h0002};
    qb = '{16'h0003};
    run_job("len1", 1'b0, 0);

    qa = '{16'h1234, 16'hFFFF, 16'h00F0, 16'h0000};
    qb = '{16'h5678, 16'hFFFF, 16'h0F00, 16'hABCD};
    run_job("len4", 1'b0, 0);

    qa.delete();
    qb.delete();
    run_job("len0", 1'b0, 0);

    qa = '{16'h1234, 16'hFFFF, 16'h00F0, 16'h0000};
    qb = '{16'h5678, 16'hFFFF, 16'h0F00, 16'hABCD};
    run_job("len4_gaps", 1'b1, 5);

    qa = '{16'hFFFF, 16'hFFFF};
    qb = '{16'hFFFF, 16'hFFFF};
    run_job("wrap32", 1'b0, 0);

    qa = '{16'h0002};
    qb = '{16'h0003};
    run_job("after_wrap", 1'b0, 0);

    for (int j = 0; j < 4; j++) begin
      qa.delete();
      qb.delete();
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
        qa.push_back(16'($urandom));
        qb.push_back(16'($urandom));
      end
      run_job("random", 1'b1, int'($urandom_range(0, 4)));
    end

    qa.delete();
    qb.delete();
    for (int k = 0; k < 255; k++) begin
      qa.push_back(16'($urandom_range(16'hF000, 16'hFFFF)));
      qb.push_back(16'($urandom_range(16'hF000, 16'hFFFF)));
    end
    run_job("len255", 1'b1, 0);

    // Abort mid-job after two of four beats.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd4;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort:busy_before", 64'(busy40), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort:idle_after", 64'(out_valid40), 64'd0);

    qa = '{16'hFFFF};
    qb = '{16'h0001};
    run_job("post_reset", 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
